// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit:
// forwarding selects and multi-cycle FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority forwarding select for one EX operand.
// EX/MEM beats MEM/WB; register 0 never forwards.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_we,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_we,
  output logic [1:0]        fwd
);

  logic hit_exm;
  logic hit_mwb;

  always_comb begin
    hit_exm = exm_we && (exm_rd == src) && (exm_rd != '0);
    hit_mwb = mwb_we && (mwb_rd == src) && (mwb_rd != '0)
              && !hit_exm;
    fwd = FWD_REG;
    unique case (1'b1)
      hit_exm: fwd = FWD_EXMEM;
      hit_mwb: fwd = FWD_MEMWB;
      default: fwd = FWD_REG;
    endcase
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding, load-use stall and multi-cycle EX hold
// for the 5-stage pipeline, with a stall-cycle counter.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic              ID_uses_rt,
  input  logic [REG_AW-1:0] ID_EX_rs,
  input  logic [REG_AW-1:0] ID_EX_rt,
  input  logic [REG_AW-1:0] ID_EX_rd,
  input  logic              ID_EX_memread,
  input  logic              ID_EX_multicycle,
  input  logic [REG_AW-1:0] EX_MEM_rd,
  input  logic              EX_MEM_regwrite,
  input  logic [REG_AW-1:0] MEM_WB_rd,
  input  logic              MEM_WB_regwrite,
  input  logic              clr_stats,
  output logic [1:0]        forward_rs,
  output logic [1:0]        forward_rt,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              ID_EX_flush,
  output logic              EX_hold,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] MC_INIT = CW'(MC_LAT - 2);

  state_e            state_q, state_d;
  logic [CW-1:0]     mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [1:0] fwd_rs;
  logic [1:0] fwd_rt;
  logic       hold;
  logic       lu;
  logic       stall;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_rs (
    .src    (ID_EX_rs),
    .exm_rd (EX_MEM_rd),
    .exm_we (EX_MEM_regwrite),
    .mwb_rd (MEM_WB_rd),
    .mwb_we (MEM_WB_regwrite),
    .fwd    (fwd_rs)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_rt (
    .src    (ID_EX_rt),
    .exm_rd (EX_MEM_rd),
    .exm_we (EX_MEM_regwrite),
    .mwb_rd (MEM_WB_rd),
    .mwb_we (MEM_WB_regwrite),
    .fwd    (fwd_rt)
  );

  // Gating with rst_n releases the pipeline while reset is held.
  always_comb begin
    hold = rst_n && (
      ((state_q == IDLE) && ID_EX_multicycle) ||
      ((state_q == MC_BUSY) && (mc_cnt_q != '0)));
    lu = rst_n && ID_EX_memread && (ID_EX_rd != '0) &&
         ((ID_EX_rd == ID_rs) ||
          (ID_uses_rt && (ID_EX_rd == ID_rt)));
    stall = hold || lu;
  end

  always_comb begin
    forward_rs  = rst_n ? fwd_rs : FWD_REG;
    forward_rt  = rst_n ? fwd_rt : FWD_REG;
    pc_write    = !stall;
    IF_ID_write = !stall;
    ID_EX_flush = lu && !hold;
    EX_hold     = hold;
    mc_busy     = (state_q == MC_BUSY);
    stall_count = stall_cnt_q;
  end

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ID_EX_multicycle) begin
          state_d  = MC_BUSY;
          mc_cnt_d = MC_INIT;
        end
      end
      MC_BUSY: begin
        if (mc_cnt_q != '0) mc_cnt_d = mc_cnt_q - CW'(1);
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stats) stall_cnt_d = '0;
    else if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
